// File: rtl/posit_decoder_pipe.sv
// posit_decoder_pipe
// Three-stage pipelined posit decoder for any width N (8..32) and exponent
// size ES (0..3). One word per cycle; backpressure stalls the whole pipe.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      producer offers in_posit this cycle
//   in_ready      decoder takes the word at this edge (= ~out_valid | out_ready)
//   in_posit      N-bit posit word
//   out_valid     decoded result present
//   out_ready     consumer takes the result at this edge
//   out_sign      sign bit of the word
//   out_regime    signed regime k
//   out_exp       exponent field (EW bits; tied to 0 when ES = 0)
//   out_frac      fraction, left-aligned, hidden bit excluded
//   out_scale     signed scale k*2^ES + exp
//   out_zero      word was all zeros
//   out_nar       word was NaR (1 followed by zeros)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds its word until it is taken; out_* hold steady while
// out_valid=1 and out_ready=0. A word taken at edge t is handed off at edge t+3
// when the consumer does not stall.
module posit_decoder_pipe #(
  parameter int N  = 16,
  parameter int ES = 1,
  localparam int RW = $clog2(N) + 1,
  localparam int FW = N - ES - 3,
  localparam int SW = RW + ES,
  // A port cannot be zero bits wide, so ES = 0 keeps a single constant-0 bit.
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic signed [RW-1:0] out_regime,
  output logic [EW-1:0]        out_exp,
  output logic [FW-1:0]        out_frac,
  output logic signed [SW-1:0] out_scale,
  output logic                 out_zero,
  output logic                 out_nar
);

  localparam logic [N-2:0]  BODY_ONE = {{(N-2){1'b0}}, 1'b1};
  localparam logic [RW-1:0] RW_ONE   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  NAR_WORD = {1'b1, {(N-1){1'b0}}};

  // Every stage register moves together; a stalled output freezes all of them.
  logic adv;
  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  // Stage 1: sign, magnitude body, special-word flags
  logic         v1_q, v1_d, sign1_q, sign1_d, zero1_q, zero1_d, nar1_q, nar1_d;
  logic [N-2:0] body1_q, body1_d;

  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    zero1_d = zero1_q;
    nar1_d  = nar1_q;
    body1_d = body1_q;
    if (adv) begin
      v1_d = in_valid;
      if (in_valid) begin
        sign1_d = in_posit[N-1];
        body1_d = in_posit[N-1] ? (~in_posit[N-2:0] + BODY_ONE) : in_posit[N-2:0];
        zero1_d = (in_posit == '0);
        nar1_d  = (in_posit == NAR_WORD);
      end
    end
  end

  // Stage 2: regime run length and the bits that follow its terminator
  logic                 run_bit, in_run;
  logic [RW-1:0]        run_len;
  logic signed [RW-1:0] k_raw;
  logic [N-4:0]         rest_raw;
  logic                 v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d, nar2_q, nar2_d;
  logic signed [RW-1:0] k2_q, k2_d;
  logic [N-4:0]         rest2_q, rest2_d;

  always_comb begin
    run_bit = body1_q[N-2];
    in_run  = 1'b1;
    run_len = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (in_run && (body1_q[i] == run_bit)) run_len = run_len + RW_ONE;
      else                                   in_run  = 1'b0;
    end
    k_raw = run_bit ? $signed(run_len - RW_ONE) : -$signed(run_len);
    // Shifting by run_len+1 left-aligns the post-terminator bits in N-1 bits;
    // their top N-3 bits are exactly the low N-3 bits of a shift by run_len-1.
    // Bits shifted in from below are zeros, which models truncated fields.
    rest_raw = (N-3)'(body1_q << (run_len - RW_ONE));
  end

  always_comb begin
    v2_d    = v2_q;
    sign2_d = sign2_q;
    zero2_d = zero2_q;
    nar2_d  = nar2_q;
    k2_d    = k2_q;
    rest2_d = rest2_q;
    if (adv) begin
      v2_d    = v1_q;
      sign2_d = sign1_q;
      zero2_d = zero1_q;
      nar2_d  = nar1_q;
      // Zero would otherwise decode as k = -(N-1); specials carry no fields.
      k2_d    = (zero1_q | nar1_q) ? '0 : k_raw;
      rest2_d = (zero1_q | nar1_q) ? '0 : rest_raw;
    end
  end

  // Stage 3: exponent, fraction, scale (output register)
  logic [EW-1:0]        exp_raw;
  logic [FW-1:0]        frac_raw;
  logic signed [SW-1:0] scale_raw;
  logic                 v3_q, v3_d, sign3_q, sign3_d, zero3_q, zero3_d, nar3_q, nar3_d;
  logic signed [RW-1:0] k3_q, k3_d;
  logic [EW-1:0]        exp3_q, exp3_d;
  logic [FW-1:0]        frac3_q, frac3_d;
  logic signed [SW-1:0] scale3_q, scale3_d;

  always_comb begin
    if (ES > 0) exp_raw = rest2_q[N-4 -: EW];
    else        exp_raw = '0;
    frac_raw  = rest2_q[N-4-ES -: FW];
    scale_raw = (SW'(k2_q) <<< ES) + $signed(SW'(exp_raw));
  end

  always_comb begin
    v3_d     = v3_q;
    sign3_d  = sign3_q;
    zero3_d  = zero3_q;
    nar3_d   = nar3_q;
    k3_d     = k3_q;
    exp3_d   = exp3_q;
    frac3_d  = frac3_q;
    scale3_d = scale3_q;
    if (adv) begin
      v3_d     = v2_q;
      sign3_d  = sign2_q;
      zero3_d  = zero2_q;
      nar3_d   = nar2_q;
      k3_d     = k2_q;
      exp3_d   = exp_raw;
      frac3_d  = frac_raw;
      scale3_d = scale_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; sign1_q <= 1'b0; zero1_q <= 1'b0; nar1_q <= 1'b0; body1_q <= '0;
      v2_q <= 1'b0; sign2_q <= 1'b0; zero2_q <= 1'b0; nar2_q <= 1'b0;
      k2_q <= '0;   rest2_q <= '0;
      v3_q <= 1'b0; sign3_q <= 1'b0; zero3_q <= 1'b0; nar3_q <= 1'b0;
      k3_q <= '0;   exp3_q  <= '0;   frac3_q <= '0;   scale3_q <= '0;
    end else begin
      v1_q <= v1_d; sign1_q <= sign1_d; zero1_q <= zero1_d; nar1_q <= nar1_d; body1_q <= body1_d;
      v2_q <= v2_d; sign2_q <= sign2_d; zero2_q <= zero2_d; nar2_q <= nar2_d;
      k2_q <= k2_d; rest2_q <= rest2_d;
      v3_q <= v3_d; sign3_q <= sign3_d; zero3_q <= zero3_d; nar3_q <= nar3_d;
      k3_q <= k3_d; exp3_q  <= exp3_d;  frac3_q <= frac3_d; scale3_q <= scale3_d;
    end
  end

  assign out_valid  = v3_q;
  assign out_sign   = sign3_q;
  assign out_regime = k3_q;
  assign out_exp    = exp3_q;
  assign out_frac   = frac3_q;
  assign out_scale  = scale3_q;
  assign out_zero   = zero3_q;
  assign out_nar    = nar3_q;

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// tb_posit_decoder_pipe
// Drives three decoder instances (N=16/ES=1, N=8/ES=0, N=32/ES=2) and checks
// every handed-off result against a bit-walking posit reference model or, for
// the documented example words, against literal expected decodes.
module tb_posit_decoder_pipe;

  typedef struct {
    int     sign;
    int     k;
    int     e;
    longint frac;
    int     scale;
    int     zero;
    int     nar;
  } dec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic               i16_valid, i16_ready, o16_valid, o16_ready, o16_sign, o16_zero, o16_nar;
  logic [15:0]        i16_posit;
  logic signed [4:0]  o16_regime;
  logic [0:0]         o16_exp;
  logic [11:0]        o16_frac;
  logic signed [5:0]  o16_scale;

  logic               i8_valid, i8_ready, o8_valid, o8_ready, o8_sign, o8_zero, o8_nar;
  logic [7:0]         i8_posit;
  logic signed [3:0]  o8_regime;
  logic [0:0]         o8_exp;
  logic [4:0]         o8_frac;
  logic signed [3:0]  o8_scale;

  logic               i32_valid, i32_ready, o32_valid, o32_ready, o32_sign, o32_zero, o32_nar;
  logic [31:0]        i32_posit;
  logic signed [5:0]  o32_regime;
  logic [1:0]         o32_exp;
  logic [26:0]        o32_frac;
  logic signed [7:0]  o32_scale;

  posit_decoder_pipe #(.N(16), .ES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(i16_valid), .in_ready(i16_ready), .in_posit(i16_posit),
    .out_valid(o16_valid), .out_ready(o16_ready), .out_sign(o16_sign), .out_regime(o16_regime),
    .out_exp(o16_exp), .out_frac(o16_frac), .out_scale(o16_scale), .out_zero(o16_zero),
    .out_nar(o16_nar));

  posit_decoder_pipe #(.N(8), .ES(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(i8_valid), .in_ready(i8_ready), .in_posit(i8_posit),
    .out_valid(o8_valid), .out_ready(o8_ready), .out_sign(o8_sign), .out_regime(o8_regime),
    .out_exp(o8_exp), .out_frac(o8_frac), .out_scale(o8_scale), .out_zero(o8_zero),
    .out_nar(o8_nar));

  posit_decoder_pipe #(.N(32), .ES(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(i32_valid), .in_ready(i32_ready), .in_posit(i32_posit),
    .out_valid(o32_valid), .out_ready(o32_ready), .out_sign(o32_sign), .out_regime(o32_regime),
    .out_exp(o32_exp), .out_frac(o32_frac), .out_scale(o32_scale), .out_zero(o32_zero),
    .out_nar(o32_nar));

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] exp_q[$];
  dec_t        exp16_q[$], exp8_q[$], exp32_q[$];
  int          cyc16_q[$], cyc8_q[$], cyc32_q[$];
  bit          lat_strict, use_tbl, stall16, acc16;
  dec_t        next_tbl;
  logic [26:0] snap16_q;
  dec_t        tbl[7];
  logic [15:0] tbl_w[7];

  // ---------------- reference model ----------------
  function automatic int bit_at(longint v, int p);
    if (p < 0) return 0;
    return int'((v >> p) & 1);
  endfunction

  function automatic dec_t ref_dec(longint w, int n, int es);
    dec_t   d;
    longint mag;
    int     r, m, p;
    d = '{default: 0};
    if (w == 0) begin d.zero = 1; return d; end
    if (w == (longint'(1) << (n - 1))) begin d.sign = 1; d.nar = 1; return d; end
    d.sign = bit_at(w, n - 1);
    // Magnitude of a negative posit is its n-bit two's complement.
    mag = (d.sign == 1) ? ((longint'(1) << n) - w) : w;
    r = bit_at(mag, n - 2);
    m = 0;
    p = n - 2;
    while (p >= 0 && bit_at(mag, p) == r) begin m++; p--; end
    d.k = (r == 1) ? m - 1 : -m;
    p--;  // step over the terminating bit (or past bit 0)
    for (int j = 0; j < es; j++) begin d.e = d.e * 2 + bit_at(mag, p); p--; end
    for (int j = 0; j < n - es - 3; j++) begin d.frac = d.frac * 2 + bit_at(mag, p); p--; end
    d.scale = d.k * (1 << es) + d.e;
    return d;
  endfunction

  function automatic dec_t mk(int s, int k, int e, longint f, int sc, int z, int n);
    dec_t d;
    d.sign = s; d.k = k; d.e = e; d.frac = f; d.scale = sc; d.zero = z; d.nar = n;
    return d;
  endfunction

  // ---------------- DUT observation ----------------
  function automatic dec_t got16();
    return mk(int'(o16_sign), int'(o16_regime), int'(o16_exp), longint'(o16_frac),
              int'(o16_scale), int'(o16_zero), int'(o16_nar));
  endfunction
  function automatic dec_t got8();
    return mk(int'(o8_sign), int'(o8_regime), int'(o8_exp), longint'(o8_frac),
              int'(o8_scale), int'(o8_zero), int'(o8_nar));
  endfunction
  function automatic dec_t got32();
    return mk(int'(o32_sign), int'(o32_regime), int'(o32_exp), longint'(o32_frac),
              int'(o32_scale), int'(o32_zero), int'(o32_nar));
  endfunction
  function automatic logic [26:0] snap16();
    return {o16_sign, o16_regime, o16_exp, o16_frac, o16_scale, o16_zero, o16_nar};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, longint obs, longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp_dec(string tag, dec_t g, dec_t x);
    chk({tag, "_sign"},  g.sign,  x.sign);
    chk({tag, "_k"},     g.k,     x.k);
    chk({tag, "_exp"},   g.e,     x.e);
    chk({tag, "_frac"},  g.frac,  x.frac);
    chk({tag, "_scale"}, g.scale, x.scale);
    chk({tag, "_zero"},  g.zero,  x.zero);
    chk({tag, "_nar"},   g.nar,   x.nar);
  endtask

  // One clock: observe handshakes about to happen at the next edge, then step.
  task automatic tick();
    dec_t        d;
    logic [15:0] w;
    int          c;
    #1;
    acc16 = 1'b0;
    if (stall16) begin
      chk("stall_valid16", longint'(o16_valid), 1);
      chk("stall_hold16", longint'(snap16()), longint'(snap16_q));
    end
    if (!rst && o16_valid && o16_ready) begin
      chk("out16_expected", longint'(exp16_q.size() > 0), 1);
      if (exp16_q.size() > 0) begin
        d = exp16_q.pop_front();
        w = exp_q.pop_front();
        c = cyc16_q.pop_front();
        cmp_dec($sformatf("dec16_%04h", w), got16(), d);
        if (lat_strict) chk("latency16", cyc + 1 - c, 3);
      end
    end
    if (!rst && i16_valid && i16_ready) begin
      exp_q.push_back(i16_posit);
      exp16_q.push_back(use_tbl ? next_tbl : ref_dec(longint'(i16_posit), 16, 1));
      cyc16_q.push_back(cyc + 1);
      acc16 = 1'b1;
    end
    stall16 = o16_valid && !o16_ready && !rst;
    if (stall16) begin
      snap16_q = snap16();
      chk("in_ready_stall16", longint'(i16_ready), 0);
    end
    if (!rst && o8_valid && o8_ready) begin
      chk("out8_expected", longint'(exp8_q.size() > 0), 1);
      if (exp8_q.size() > 0) begin
        cmp_dec("dec8", got8(), exp8_q.pop_front());
        chk("latency8", cyc + 1 - cyc8_q.pop_front(), 3);
      end
    end
    if (!rst && i8_valid && i8_ready) begin
      exp8_q.push_back(ref_dec(longint'(i8_posit), 8, 0));
      cyc8_q.push_back(cyc + 1);
    end
    if (!rst && o32_valid && o32_ready) begin
      chk("out32_expected", longint'(exp32_q.size() > 0), 1);
      if (exp32_q.size() > 0) begin
        cmp_dec("dec32", got32(), exp32_q.pop_front());
        chk("latency32", cyc + 1 - cyc32_q.pop_front(), 3);
      end
    end
    if (!rst && i32_valid && i32_ready) begin
      exp32_q.push_back(ref_dec(longint'(i32_posit), 32, 2));
      cyc32_q.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    o16_ready = 1'b1;
    while ((exp16_q.size() + exp8_q.size() + exp32_q.size()) > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_empty", exp16_q.size() + exp8_q.size() + exp32_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          sent, guard;
    logic [15:0] w;

    tbl_w[0] = 16'h4000; tbl[0] = mk(0,   0, 0, 0,      0, 0, 0);
    tbl_w[1] = 16'h5A00; tbl[1] = mk(0,   0, 1, 'hA00,  1, 0, 0);
    tbl_w[2] = 16'hC000; tbl[2] = mk(1,   0, 0, 0,      0, 0, 0);
    tbl_w[3] = 16'h7FFF; tbl[3] = mk(0,  14, 0, 0,     28, 0, 0);
    tbl_w[4] = 16'h0001; tbl[4] = mk(0, -14, 0, 0,    -28, 0, 0);
    tbl_w[5] = 16'h0000; tbl[5] = mk(0,   0, 0, 0,      0, 1, 0);
    tbl_w[6] = 16'h8000; tbl[6] = mk(1,   0, 0, 0,      0, 0, 1);

    rst = 1'b1;
    i16_valid = 1'b0; i16_posit = '0; o16_ready = 1'b1;
    i8_valid  = 1'b0; i8_posit  = '0; o8_ready  = 1'b1;
    i32_valid = 1'b0; i32_posit = '0; o32_ready = 1'b1;
    lat_strict = 1'b1; use_tbl = 1'b0; stall16 = 1'b0; acc16 = 1'b0;
    next_tbl = '{default: 0};
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid16", longint'(o16_valid), 0);
    chk("rst_outputs16", longint'(snap16()), 0);
    chk("rst_in_ready16", longint'(i16_ready), 1);
    chk("rst_out_valid8", longint'(o8_valid), 0);
    chk("rst_out_valid32", longint'(o32_valid), 0);

    // Documented example words, back to back, literal expectations
    use_tbl = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i16_valid = 1'b1;
      i16_posit = tbl_w[i];
      next_tbl  = tbl[i];
      tick();
    end
    i16_valid = 1'b0;
    use_tbl   = 1'b0;
    drain(50);

    // Backpressure: 20 random words, random consumer stalls
    lat_strict = 1'b0;
    sent  = 0;
    guard = 0;
    w = 16'($urandom);
    i16_posit = w;
    while (sent < 20 && guard < 600) begin
      if (!i16_valid) i16_valid = ($urandom_range(0, 2) != 0);
      o16_ready = ($urandom_range(0, 1) == 1);
      tick();
      if (acc16) begin
        sent++;
        w = 16'($urandom);
        i16_posit = w;
        i16_valid = 1'b0;
      end
      guard++;
    end
    chk("bp_words_sent", sent, 20);
    i16_valid = 1'b0;
    drain(50);
    lat_strict = 1'b1;

    // Reset with three words in flight; a word offered during reset is dropped
    o16_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i16_valid = 1'b1;
      i16_posit = 16'($urandom);
      tick();
    end
    i16_valid = 1'b1;
    i16_posit = 16'h5A00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i16_valid = 1'b0;
    #1;
    chk("midrst_out_valid16", longint'(o16_valid), 0);
    chk("midrst_outputs16", longint'(snap16()), 0);
    chk("midrst_in_ready16", longint'(i16_ready), 1);
    exp_q.delete();
    exp16_q.delete();
    cyc16_q.delete();
    stall16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("postrst_idle16", longint'(o16_valid), 0);
      tick();
    end
    i16_valid = 1'b1;
    i16_posit = 16'h7FFF;
    tick();
    i16_valid = 1'b0;
    drain(20);

    // Parameter sweep: all 256 N=8 codes, 10k random N=32 words
    for (int i = 0; i < 10000; i++) begin
      i32_valid = 1'b1;
      i32_posit = $urandom;
      i8_valid  = (i < 256);
      i8_posit  = 8'(i);
      tick();
    end
    i8_valid  = 1'b0;
    i32_valid = 1'b0;
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
